// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined four-mode barrel shifter with valid/ready handshake
// Optional feature macro: PIPELINED_BARREL_SHIFTER_STICKY_EN (adds sticky_o, OR of discarded bits)
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] val_i,
  input  logic [SHW-1:0]   shift_n_i,
  input  logic [1:0]       mode_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  ,
  output logic             sticky_o
`endif
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // The whole pipeline moves as one: it advances whenever the output slot is free or being drained.
  logic adv;
  assign adv        = out_ready_i | ~out_valid_o;
  assign in_ready_o = adv;

  // Per-stage register outputs, collected so each stage can read its predecessor.
  logic             valid_s [SHW];
  logic [WIDTH-1:0] data_s  [SHW];
  logic [SHW-1:0]   amt_s   [SHW];
  logic [1:0]       mode_s  [SHW];
  logic [TAG_W-1:0] tag_s   [SHW];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  logic             sticky_s [SHW];
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int S = 1 << k;

    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [SHW-1:0]   a_in;
    logic [1:0]       m_in;
    logic [TAG_W-1:0] t_in;
    logic [WIDTH-1:0] d_shift;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    logic [1:0]       mode_q;
    logic [TAG_W-1:0] tag_q;

    // Lower amount bits are already consumed by earlier stages; they ride along unused.
    logic unused_amt_bits;
    assign unused_amt_bits = ^a_in;

    if (k == 0) begin : g_first
      assign v_in = in_valid_i & adv;
      assign d_in = val_i;
      assign a_in = shift_n_i;
      assign m_in = mode_i;
      assign t_in = tag_i;
    end else begin : g_next
      assign v_in = valid_s[k-1];
      assign d_in = data_s[k-1];
      assign a_in = amt_s[k-1];
      assign m_in = mode_s[k-1];
      assign t_in = tag_s[k-1];
    end

    // Shift by this stage's fixed power of two when its amount bit is set.
    always_comb begin
      d_shift = d_in;
      if (a_in[k]) begin
        case (m_in)
          MODE_SLL: d_shift = d_in << S;
          MODE_SRL: d_shift = d_in >> S;
          MODE_SRA: d_shift = (d_in >> S) | ({WIDTH{d_in[WIDTH-1]}} << (WIDTH - S));
          default:  d_shift = (d_in << S) | (d_in >> (WIDTH - S));
        endcase
      end
    end

    // Stage registers load together on advance and hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        amt_q   <= '0;
        mode_q  <= '0;
        tag_q   <= '0;
      end else if (adv) begin
        valid_q <= v_in;
        data_q  <= d_shift;
        amt_q   <= a_in;
        mode_q  <= m_in;
        tag_q   <= t_in;
      end
    end

    assign valid_s[k] = valid_q;
    assign data_s[k]  = data_q;
    assign amt_s[k]   = amt_q;
    assign mode_s[k]  = mode_q;
    assign tag_s[k]   = tag_q;

`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    logic s_in;
    logic drop;
    logic sticky_q;

    if (k == 0) begin : g_sticky_first
      assign s_in = 1'b0;
    end else begin : g_sticky_next
      assign s_in = sticky_s[k-1];
    end

    // Bits pushed off the end by this stage; rotation never loses bits.
    always_comb begin
      drop = 1'b0;
      if (a_in[k]) begin
        case (m_in)
          MODE_SLL: drop = |(d_in >> (WIDTH - S));
          MODE_SRL: drop = |(d_in << (WIDTH - S));
          MODE_SRA: drop = |(d_in << (WIDTH - S));
          default:  drop = 1'b0;
        endcase
      end
    end

    // Accumulate the discarded-bit OR alongside the data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sticky_q <= 1'b0;
      end else if (adv) begin
        sticky_q <= s_in | drop;
      end
    end

    assign sticky_s[k] = sticky_q;
`endif
  end

  assign out_valid_o = valid_s[SHW-1];
  assign result_o    = data_s[SHW-1];
  assign tag_o       = tag_s[SHW-1];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  assign sticky_o    = sticky_s[SHW-1];
`endif

  // The last stage's amount and mode have no consumer downstream.
  logic unused_last;
  assign unused_last = ^{amt_s[SHW-1], mode_s[SHW-1]};

endmodule
